// File: rtl/simon_pkg.sv
// Shared definitions for the colour-sequence datapath: colour codes, the
// capture FSM state set, sequence geometry and the one-hot decode helpers.
// Used by the display, capture and check stages.
package simon_pkg;

  localparam int SEQ_W       = 32;
  localparam int MAX_COLOURS = 16;
  localparam int NUM_BTN     = 4;

  typedef enum logic [1:0] {
    COL_R = 2'd0,
    COL_G = 2'd1,
    COL_B = 2'd2,
    COL_Y = 2'd3
  } colour_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_WAIT_PRESS,
    ST_WAIT_RELEASE,
    ST_DONE
  } state_e;

  // Buttons are {Y,B,G,R} = btn[3:0]; only meaningful for one-hot input.
  function automatic colour_e onehot_to_colour(input logic [NUM_BTN-1:0] oh);
    case (oh)
      4'b0010: return COL_G;
      4'b0100: return COL_B;
      4'b1000: return COL_Y;
      default: return COL_R;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [NUM_BTN-1:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Single-button input conditioner: 2-flop synchroniser followed by a
// stable-level filter. The level output flips only after DEBOUNCE_CYCLES
// consecutive synchronised samples that differ from the current level,
// giving 2 + DEBOUNCE_CYCLES cycles from a raw edge to the level edge.
// Ports:
//   clk, rst_n  clock, async active-low reset (level resets to released)
//   btn_i       raw asynchronous button
//   level_o     debounced level
module button_debouncer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic [15:0] cnt_q, cnt_d;

  // Any sample equal to the current level restarts the run count, so a
  // glitch shorter than DEBOUNCE_CYCLES never reaches the output.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if ({1'b0, cnt_q} + 17'd1 >= {1'b0, DEBOUNCE_CYCLES}) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/player_input_capture.sv
// Captures the player's colour presses after the display phase and packs
// them into the same 32-bit slot layout the display path reads.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   en            capture runs while high; low returns to IDLE (seq_out kept)
//   btn[3:0]      raw buttons {Y,B,G,R}
//   seq_len[3:0]  expected colour count - 1, sampled on leaving IDLE
//   colour_valid  1-cycle pulse per accepted colour
//   colour_val    last accepted colour
//   seq_out       packed sequence, colour k at [2k+1:2k]
//   complete      high in DONE
//   timeout       high with complete when a per-colour timeout ended capture
//   multi_press   1-cycle pulse when more than one button was pressed
module player_input_capture
  import simon_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
  parameter logic [23:0] TIMEOUT_CYCLES  = 24'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_BTN-1:0] btn,
  input  logic [3:0]         seq_len,
  output logic               colour_valid,
  output logic [1:0]         colour_val,
  output logic [SEQ_W-1:0]   seq_out,
  output logic               complete,
  output logic               timeout,
  output logic               multi_press
);

  logic [NUM_BTN-1:0] db;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn[g]),
      .level_o(db[g])
    );
  end

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d, len_q, len_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [1:0]       col_q, col_d;
  logic             cv_q, cv_d, mp_q, mp_d, to_q, to_d;
  logic             got_q, got_d;   // current press was a valid colour
  logic [23:0]      tmr_q, tmr_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    seq_d   = seq_q;
    col_d   = col_q;
    cv_d    = 1'b0;
    mp_d    = 1'b0;
    to_d    = to_q;
    got_d   = got_q;
    tmr_d   = tmr_q;
    if (!en) begin
      state_d = ST_IDLE;
      to_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          seq_d   = '0;
          idx_d   = '0;
          len_d   = seq_len;
          to_d    = 1'b0;
          got_d   = 1'b0;
          state_d = ST_ARMED;
        end
        // A button still held from the display phase must be let go first.
        ST_ARMED: begin
          if (db == '0) begin
            tmr_d   = '0;
            state_d = ST_WAIT_PRESS;
          end
        end
        // A press outranks a timeout landing in the same cycle.
        ST_WAIT_PRESS: begin
          if (db != '0) begin
            if (is_onehot(db)) begin
              seq_d[{idx_q, 1'b0} +: 2] = onehot_to_colour(db);
              col_d = onehot_to_colour(db);
              cv_d  = 1'b1;
              got_d = 1'b1;
            end else begin
              mp_d  = 1'b1;
              got_d = 1'b0;
            end
            state_d = ST_WAIT_RELEASE;
          end else if (TIMEOUT_CYCLES != '0 &&
                       {1'b0, tmr_q} + 25'd1 >= {1'b0, TIMEOUT_CYCLES}) begin
            to_d    = 1'b1;
            state_d = ST_DONE;
          end else if (tmr_q != '1) begin
            tmr_d = tmr_q + 24'd1;
          end
        end
        // A rejected multi-press leaves the index where it was.
        ST_WAIT_RELEASE: begin
          if (db == '0) begin
            tmr_d = '0;
            if (got_q && idx_q == len_q) begin
              state_d = ST_DONE;
            end else begin
              if (got_q) idx_d = idx_q + 4'd1;
              state_d = ST_WAIT_PRESS;
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      seq_q   <= '0;
      col_q   <= '0;
      cv_q    <= 1'b0;
      mp_q    <= 1'b0;
      to_q    <= 1'b0;
      got_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      seq_q   <= seq_d;
      col_q   <= col_d;
      cv_q    <= cv_d;
      mp_q    <= mp_d;
      to_q    <= to_d;
      got_q   <= got_d;
      tmr_q   <= tmr_d;
    end
  end

  assign colour_valid = cv_q;
  assign colour_val   = col_q;
  assign seq_out      = seq_q;
  assign complete     = (state_q == ST_DONE);
  assign timeout      = to_q;
  assign multi_press  = mp_q;

endmodule

// File: tb/tb_player_input_capture.sv
module tb_player_input_capture;

  localparam logic [15:0] DB = 16'd4;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [3:0]  btn = '0, seq_len = '0;
  logic        cv, mp, cpl, tmo;
  logic [1:0]  cval;
  logic [31:0] seq;
  logic        cv2, mp2, cpl2, tmo2;
  logic [1:0]  cval2;
  logic [31:0] seq2;

  player_input_capture #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(24'd0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .btn(btn), .seq_len(seq_len),
    .colour_valid(cv), .colour_val(cval), .seq_out(seq), .complete(cpl),
    .timeout(tmo), .multi_press(mp));

  player_input_capture #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(24'd50)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .en(en), .btn(btn), .seq_len(seq_len),
    .colour_valid(cv2), .colour_val(cval2), .seq_out(seq2), .complete(cpl2),
    .timeout(tmo2), .multi_press(mp2));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int n_valid = 0, n_multi = 0;
  logic [1:0] obs [0:4095];

  // Scoreboard input: every colour pulse seen on the untimed DUT, in order.
  always @(negedge clk) begin
    if (rst_n && cv && n_valid < 4096) begin
      obs[n_valid] <= cval;
      n_valid      <= n_valid + 1;
    end
    if (rst_n && mp) n_multi <= n_multi + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] b, input int h, input int g);
    btn = b;
    tick(h);
    btn = '0;
    tick(g);
  endtask

  // Back to IDLE, then arm with a new length; two cycles reach WAIT_PRESS.
  task automatic start(input logic [3:0] len);
    en = 1'b0;
    btn = '0;
    tick(3);
    seq_len = len;
    en = 1'b1;
    tick(2);
  endtask

  // Reference colour for a one-hot button pattern {Y,B,G,R}.
  function automatic logic [1:0] colour_of(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b == (4'b1 << i)) return 2'(i);
    return 2'd0;
  endfunction

  typedef struct {
    logic [3:0]  len;
    int          n;
    logic [71:0] b;      // press i in nibble i
    logic [31:0] exp_seq;
    int          exp_v;
    int          exp_m;
  } vec_t;

  vec_t vt [6];

  initial begin
    int v0, m0, first, len, k, em, r, a, b2, c;
    logic [31:0] exp_seq, obs_pack;
    logic [3:0] nib;
    int bounce [0:5];

    vt[0] = '{4'd2,  3,  72'h841,                 32'h0000_0038, 3,  0};
    vt[1] = '{4'd1,  3,  72'h825,                 32'h0000_000D, 2,  1};
    vt[2] = '{4'd15, 16, 72'h8888_8888_8888_8888, 32'hFFFF_FFFF, 16, 0};
    vt[3] = '{4'd0,  1,  72'h4,                   32'h0000_0002, 1,  0};
    vt[4] = '{4'd3,  5,  72'h841A2,               32'h0000_00E1, 4,  1};
    vt[5] = '{4'd7,  8,  72'h1248_8421,           32'h0000_1BE4, 8,  0};

    // Reset state
    tick(2);
    chk("rst_flags", {28'd0, cv, mp, cpl, tmo}, 32'd0);
    chk("rst_seq", seq, 32'd0);
    chk("rst_cval", {30'd0, cval}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Table-driven clean sequences; an extra press after DONE must be ignored.
    for (int t = 0; t < 6; t++) begin
      start(vt[t].len);
      v0 = n_valid;
      m0 = n_multi;
      for (int i = 0; i < vt[t].n; i++) begin
        nib = vt[t].b[4*i +: 4];
        press(nib, 8, 8);
      end
      tick(4);
      chk($sformatf("vec%0d_seq", t), seq, vt[t].exp_seq);
      chk($sformatf("vec%0d_complete", t), {31'd0, cpl}, 32'd1);
      chk($sformatf("vec%0d_nvalid", t), n_valid - v0, vt[t].exp_v);
      chk($sformatf("vec%0d_nmulti", t), n_multi - m0, vt[t].exp_m);
      chk($sformatf("vec%0d_timeout", t), {31'd0, tmo}, 32'd0);
      press(4'b0001, 8, 8);
      chk($sformatf("vec%0d_extra_nvalid", t), n_valid - v0, vt[t].exp_v);
      chk($sformatf("vec%0d_extra_seq", t), seq, vt[t].exp_seq);
      en = 1'b0;
      tick(1);
      chk($sformatf("vec%0d_en_low_complete", t), {31'd0, cpl}, 32'd0);
    end

    // Bouncy G: runs of 2,3,1 cycles separated by short releases, then stable.
    start(4'd0);
    v0 = n_valid;
    bounce = '{2, 1, 3, 2, 1, 1};
    for (int i = 0; i < 6; i++) begin
      btn = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      tick(bounce[i]);
    end
    press(4'b0010, 10, 10);
    chk("bounce_nvalid", n_valid - v0, 1);
    chk("bounce_cval", {30'd0, cval}, 32'd1);
    chk("bounce_seq", seq, 32'h1);
    chk("bounce_complete", {31'd0, cpl}, 32'd1);

    // G held across en rising: nothing captured until it is released.
    en = 1'b0;
    tick(3);
    seq_len = 4'd1;
    btn = 4'b0010;
    tick(10);
    v0 = n_valid;
    en = 1'b1;
    tick(12);
    chk("held_nvalid", n_valid - v0, 0);
    chk("held_complete", {31'd0, cpl}, 32'd0);
    btn = '0;
    tick(8);
    press(4'b0001, 8, 8);
    press(4'b1000, 8, 8);
    tick(4);
    chk("held_seq", seq, 32'hC);
    chk("held_nvalid2", n_valid - v0, 2);

    // Timeout: 2 cycles to reach WAIT_PRESS, then 50 idle cycles.
    en = 1'b0;
    btn = '0;
    tick(3);
    seq_len = 4'd4;
    en = 1'b1;
    first = -1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (cpl2 && first < 0) first = i;
    end
    chk("to_cycles", first, 2 + 50);
    chk("to_flag", {31'd0, tmo2}, 32'd1);
    chk("to_seq", seq2, 32'd0);
    chk("no_to_complete", {31'd0, cpl}, 32'd0);
    chk("no_to_flag", {31'd0, tmo}, 32'd0);
    @(negedge clk);
    en = 1'b0;
    tick(1);
    chk("to_clear", {30'd0, cpl2, tmo2}, 32'd0);

    // en low mid-capture keeps seq_out; re-enabling clears it.
    start(4'd3);
    press(4'b1000, 8, 8);
    press(4'b1000, 8, 8);
    chk("en_mid_seq_before", seq, 32'hF);
    en = 1'b0;
    tick(1);
    chk("en_mid_complete", {31'd0, cpl}, 32'd0);
    chk("en_mid_seq_kept", seq, 32'hF);
    tick(2);
    en = 1'b1;
    tick(1);
    chk("en_restart_clear", seq, 32'd0);
    tick(1);
    press(4'b1000, 8, 8);
    chk("rst_mid_seq_before", seq, 32'h3);
    btn = 4'b0010;
    tick(7);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_flags", {28'd0, cv, mp, cpl, tmo}, 32'd0);
    chk("rst_mid_seq", seq, 32'd0);
    chk("rst_mid_cval", {30'd0, cval}, 32'd0);
    btn = '0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Random sessions: clean presses, rejected double presses and short
    // glitches; expected colours come straight from the pressed sequence.
    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(0, 15);
      start(4'(len));
      seq_len = 4'($urandom);   // ignored after arming
      v0 = n_valid;
      m0 = n_multi;
      exp_seq = '0;
      k = 0;
      em = 0;
      while (k <= len) begin
        r = $urandom_range(0, 9);
        if (r == 0) begin
          a  = $urandom_range(0, 3);
          b2 = (a + $urandom_range(1, 3)) % 4;
          press((4'b1 << a) | (4'b1 << b2), $urandom_range(5, 12), $urandom_range(6, 12));
          em++;
        end else if (r == 1) begin
          press(4'b1 << $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(6, 12));
        end else begin
          c = $urandom_range(0, 3);
          exp_seq = exp_seq | (32'(c) << (2 * k));
          press(4'b1 << c, $urandom_range(5, 12), $urandom_range(6, 12));
          k++;
        end
      end
      tick(4);
      obs_pack = '0;
      for (int i = 0; i < 16 && v0 + i < n_valid; i++)
        obs_pack = obs_pack | (32'(obs[v0 + i]) << (2 * i));
      chk($sformatf("rnd%0d_seq", t), seq, exp_seq);
      chk($sformatf("rnd%0d_pulses", t), obs_pack, exp_seq);
      chk($sformatf("rnd%0d_nvalid", t), n_valid - v0, len + 1);
      chk($sformatf("rnd%0d_nmulti", t), n_multi - m0, em);
      chk($sformatf("rnd%0d_complete", t), {31'd0, cpl}, 32'd1);
      if (len > 0) chk($sformatf("rnd%0d_colour", t), {30'd0, cval}, 32'(colour_of(4'b1 << exp_seq[2*len +: 2])));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
